aes_iter_enc: RTL
=================

// Module: aes_iter_enc
// PURPOSE
//  Iterative AES encryptor, one round per clock, key length set by parameter (128/192/256).
//  Successor to the fixed AES-128 pipeline: explicit key-load phase, stored round keys reused across blocks,
//  ready/valid handshakes on key, data and output (with backpressure). Sits between the stream front-end and the cipher-text sink.
// PARAMETERS
//  KEY_LEN   128  key width; legal values 128, 192, 256 (any other value: elaboration error)
//  DATA_W    128  block width; fixed at 128 (parameter kept for port compatibility)
//  NO_ROUNDS derived: KEY_LEN/32+6 (10/12/14); localparam, not overridable
// PORTS
//  clk                 in   1        rising-edge clock
//  reset               in   1        synchronous, active-high
//  cipherkey_valid_in  in   1        cipher_key valid
//  cipherkey_ready     out  1        key accepted when valid&ready
//  cipher_key          in   KEY_LEN  key; bit KEY_LEN-1 = first key byte MSB (FIPS-197 order)
//  data_valid_in       in   1        plain_text valid
//  data_ready          out  1        block accepted when valid&ready
//  plain_text          in   128      bit 127 = MSB of byte 0
//  valid_out           out  1        cipher_text valid
//  out_ready           in   1        sink accepts cipher_text when valid_out&out_ready
//  cipher_text         out  128      result, same byte order
//  key_loaded          out  1        round keys valid (state READY or ENC)
// BEHAVIOUR
//  Reset: state=IDLE; cipherkey_ready=0, data_ready=0, valid_out=0, cipher_text=0, key_loaded=0; round-key store invalidated.
//  FSM IDLE -> KEYEXP -> READY <-> ENC; READY -> KEYEXP on new key.
//  IDLE: cipherkey_ready=1. Key accept: w[0..Nk-1]<=cipher_key (Nk=KEY_LEN/32), word idx i<=Nk, -> KEYEXP.
//  KEYEXP: one word/cycle, w[i]=w[i-Nk]^f(w[i-1]); f=SubWord(RotWord)^Rcon[i/Nk] if i%Nk==0,
//   SubWord if Nk==8 && i%8==4, else identity. Ends at i=4*(NO_ROUNDS+1)-1 -> READY.
//   Duration after accept edge: 40/46/52 cycles (128/192/256). cipherkey_ready=0, data_ready=0.
//  READY: cipherkey_ready=1; data_ready=~cipherkey_valid_in (key has priority on same-cycle requests).
//   New key accept in READY discards old keys -> KEYEXP; a result already in output register is kept.
//  Data accept (edge E0): st<=plain_text^rk0, rnd<=1, -> ENC. data_ready=0 in ENC.
//  ENC: edge Er (r=1..NO_ROUNDS-1): st<=MixCols(ShiftRows(SubBytes(st)))^rk_r.
//   Final round (no MixColumns) at edge E_NO_ROUNDS loads cipher_text, valid_out<=1, -> READY.
//   Latency accept->valid_out = NO_ROUNDS cycles (10/12/14); throughput 1 block per NO_ROUNDS+1 cycles.
//  Backpressure: final round fires only if valid_out==0 or out_ready==1; otherwise ENC holds at rnd=NO_ROUNDS, st unchanged.
//  Output: valid_out clears on valid_out&out_ready unless a new result loads same edge; cipher_text stable while valid_out&~out_ready.
//  cipherkey_ready=0 in IDLE? no: =1 in IDLE and READY only; keys presented in KEYEXP/ENC are not taken (held by source).
//  data_valid_in in IDLE/KEYEXP: not accepted, no error, no state change.
//  Reset mid-KEYEXP or mid-ENC: in-flight block dropped, valid_out=0, key must be reloaded.
//  rnd counter 4 bits; round-key index 4*rnd..4*rnd+3; no wrap beyond NO_ROUNDS.
// STRUCTURE
//  aes_pkg: Rcon[1..10], state enum {IDLE,KEYEXP,READY,ENC}, nr_of(key_len), xtime/mixcolumn functions.
//  Sub-module aes_sbox (8-bit combinational S-box): 16 instances in round datapath, 4 in key expansion.
//  Round-key store: register array of 4*(NO_ROUNDS+1) 32-bit words, written only in key accept/KEYEXP.
// TESTING
//  T1 KEY_LEN=128: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32, latency 10.
//  T2 KEY_LEN=192: key 000102..1617, pt 00112233445566778899aabbccddeeff -> dda97ca4864cdfe06eaf70a0ec0d7191; KEYEXP 46 cycles.
//  T3 KEY_LEN=256: key 000102..1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, latency 14.
//  T4 KEY_LEN=128 key reuse: key 10a58869d74be5a374cf867cfb473859, 4 back-to-back pt=0 -> 6d251e6944b051e04eaa6fb4dbf78465 each, 11-cycle spacing.
//  T5 backpressure: out_ready=0 for 20 cycles with 2 blocks sent -> first result held stable, second stalls in ENC, both correct in order.
//  T6 reset asserted mid-ENC, then data_valid_in without key -> valid_out stays 0, data_ready 0 until new key expanded.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the iterative encryptor.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEYEXP, READY, ENC} aes_state_e;

  function automatic int nr_of(input int key_len);
    return key_len / 32 + 6;
  endfunction

  // Round constants Rcon[1..10]; index 0 and anything above 10 never occur.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcolumn(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mixcolumn(s[127:96]), mixcolumn(s[95:64]),
            mixcolumn(s[63:32]), mixcolumn(s[31:0])};
  endfunction

  // State bytes are column-major with byte 0 in the MSBs; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [0:15][7:0] b;
    b = s;
    return {b[0],  b[5],  b[10], b[15], b[4],  b[9],  b[14], b[3],
            b[8],  b[13], b[2],  b[7],  b[12], b[1],  b[6],  b[11]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box as a flat constant table, byte 0x00 in the MSBs.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n sits at bit offset 8*(255-n), and 255-n is simply ~n for a byte.
  assign data_o = SBOX_TBL[{~data_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_iter_enc.sv
// Iterative AES encryptor (128/192/256-bit key), one round per clock, with an
// explicit key-expansion phase and ready/valid handshakes on key, data and result.
module aes_iter_enc
  import aes_pkg::*;
#(
  parameter int KEY_LEN = 128,
  parameter int DATA_W  = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cipherkey_valid_in,
  output logic               cipherkey_ready,
  input  logic [KEY_LEN-1:0] cipher_key,
  input  logic               data_valid_in,
  output logic               data_ready,
  input  logic [DATA_W-1:0]  plain_text,
  output logic               valid_out,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  cipher_text,
  output logic               key_loaded
);

  localparam int NO_ROUNDS = nr_of(KEY_LEN);
  localparam int NK        = KEY_LEN / 32;
  localparam int NW        = 4 * (NO_ROUNDS + 1);

  if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
    $error("aes_iter_enc: KEY_LEN must be 128, 192 or 256");
  end
  if (DATA_W != 128) begin : g_bad_data_w
    $error("aes_iter_enc: DATA_W must be 128");
  end

  aes_state_e           state_q;
  logic [3:0]           rnd_q;
  logic [5:0]           idx_q;
  logic [2:0]           kpos_q;
  logic [3:0]           rc_q;
  logic [127:0]         st_q;
  logic [127:0]         ct_q;
  logic                 vo_q;
  logic                 ckr_q;
  logic                 kl_q;
  logic [0:NW-1][31:0]  w_q;

  logic                 key_acc;
  logic                 data_acc;
  logic                 final_rnd;
  logic [5:0]           rk_base;
  logic [127:0]         rk;
  logic [127:0]         sb;
  logic [127:0]         sr;
  logic [127:0]         mc;
  logic [31:0]          prev_w;
  logic [31:0]          old_w;
  logic [31:0]          ks_in;
  logic [31:0]          ks_sub;
  logic [31:0]          ks_f;
  logic [31:0]          new_w;

  assign key_acc   = cipherkey_valid_in & ckr_q;
  assign data_ready = (state_q == READY) & ~cipherkey_valid_in;
  assign data_acc  = data_valid_in & data_ready;
  assign final_rnd = (rnd_q == 4'(NO_ROUNDS));

  // rnd_q is 0 whenever the FSM sits in READY, so the same mux also yields rk0.
  assign rk_base = {rnd_q, 2'b00};
  assign rk      = w_q[rk_base +: 4];

  for (genvar g = 0; g < 16; g++) begin : g_round_sbox
    aes_sbox u_sbox (.data_i(st_q[127-8*g -: 8]), .data_o(sb[127-8*g -: 8]));
  end

  assign sr = shift_rows(sb);
  assign mc = mix_columns(sr);

  assign prev_w = w_q[idx_q - 6'd1];
  assign old_w  = w_q[idx_q - 6'(NK)];
  assign ks_in  = (kpos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (.data_i(ks_in[31-8*g -: 8]), .data_o(ks_sub[31-8*g -: 8]));
  end

  always_comb begin
    // NOTE: assign a default first so no path leaves ks_f unassigned (no latch).
    ks_f = prev_w;
    if (kpos_q == 3'd0) begin
      ks_f = ks_sub ^ {rcon(rc_q), 24'h000000};
    end else if (NK == 8 && kpos_q == 3'd4) begin
      ks_f = ks_sub;
    end
  end

  assign new_w = old_w ^ ks_f;

  // NOTE: the round-key store has no reset; the FSM returning to IDLE is what
  // invalidates it, and keeping it reset-free lets it map to plain registers.
  always_ff @(posedge clk) begin
    if (key_acc) begin
      w_q[0:NK-1] <= cipher_key;
    end else if (state_q == KEYEXP) begin
      w_q[idx_q] <= new_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      idx_q   <= 6'd0;
      kpos_q  <= 3'd0;
      rc_q    <= 4'd1;
      st_q    <= '0;
      ct_q    <= '0;
      vo_q    <= 1'b0;
      ckr_q   <= 1'b0;
      kl_q    <= 1'b0;
    end else begin
      if (vo_q && out_ready) vo_q <= 1'b0;

      if (key_acc) begin
        state_q <= KEYEXP;
        ckr_q   <= 1'b0;
        kl_q    <= 1'b0;
        idx_q   <= 6'(NK);
        kpos_q  <= 3'd0;
        rc_q    <= 4'd1;
      end else begin
        unique case (state_q)
          IDLE: ckr_q <= 1'b1;

          KEYEXP: begin
            idx_q  <= idx_q + 6'd1;
            kpos_q <= (kpos_q == 3'(NK - 1)) ? 3'd0 : kpos_q + 3'd1;
            if (kpos_q == 3'd0) rc_q <= rc_q + 4'd1;
            if (idx_q == 6'(NW - 1)) begin
              state_q <= READY;
              ckr_q   <= 1'b1;
              kl_q    <= 1'b1;
            end
          end

          READY: begin
            if (data_acc) begin
              st_q    <= plain_text ^ rk;
              rnd_q   <= 4'd1;
              state_q <= ENC;
              ckr_q   <= 1'b0;
            end
          end

          ENC: begin
            if (!final_rnd) begin
              st_q  <= mc ^ rk;
              rnd_q <= rnd_q + 4'd1;
            end else if (!vo_q || out_ready) begin
              // A held result may be consumed on this same edge; the new load wins.
              ct_q    <= sr ^ rk;
              vo_q    <= 1'b1;
              rnd_q   <= 4'd0;
              state_q <= READY;
              ckr_q   <= 1'b1;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cipherkey_ready = ckr_q;
  assign valid_out       = vo_q;
  assign cipher_text     = ct_q;
  assign key_loaded      = kl_q;

endmodule
